// File: rtl/debug_readback_pkg.sv
// Shared debug definitions: op codes, response status layout and the readback FSM states.
package debug_readback_pkg;

  localparam logic [7:0] DBG_OP_READIMEM = 8'h04;
  localparam logic [7:0] DBG_OP_READDMEM = 8'h06;

  localparam int STAT_TIMEOUT_BIT = 7;
  localparam int STAT_OVERRUN_BIT = 6;
  localparam int SEQ_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PUBLISH
  } rb_state_t;

  function automatic logic is_read_op(input logic [7:0] op);
    return (op == DBG_OP_READIMEM) || (op == DBG_OP_READDMEM);
  endfunction

endpackage

// File: rtl/debug_readback_if.sv
// Debug op in, CPU memory read port, and the JTAG-facing response/handshake signals.
interface debug_readback_if;
  logic        req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_addr;
  logic        imem_re;
  logic        dmem_re;
  logic [31:0] mem_raddr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] resp_data;
  logic [7:0]  resp_status;
  logic        resp_toggle;
  logic        jtag_ack_toggle;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_addr,
    input  imem_rvalid, imem_rdata, dmem_rvalid, dmem_rdata,
    input  jtag_ack_toggle,
    output imem_re, dmem_re, mem_raddr,
    output resp_data, resp_status, resp_toggle, busy
  );

  modport master (
    output req_valid, req_op, req_addr,
    output imem_rvalid, imem_rdata, dmem_rvalid, dmem_rdata,
    output jtag_ack_toggle,
    input  imem_re, dmem_re, mem_raddr,
    input  resp_data, resp_status, resp_toggle, busy
  );
endinterface

// File: rtl/ff_sync.sv
// Two-flop synchronizer for slow or level signals crossing into the clk domain.
module ff_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/debug_readback.sv
// CPU-domain debug read path: issues one memory read per READIMEM/READDMEM and
// publishes the tagged result to the JTAG domain with a toggle handshake.
module debug_readback
  import debug_readback_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic             cpu_clk,
  input logic             cpu_rstn,
  debug_readback_if.slave bus
);
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rb_state_t        state, state_nxt;
  logic             rst_p;
  logic             ack_sync;
  logic             serviced, accept, publish, timed_out, overrun_set;
  logic             sel_dmem;
  logic [CNT_W-1:0] wait_cnt;
  logic             rvalid_p1;
  logic [31:0]      rdata_p1;
  logic             overrun;
  logic [SEQ_W-1:0] seq, seq_inc;
  logic [7:0]       status_nxt;
  logic             imem_re, dmem_re, resp_toggle;
  logic [31:0]      mem_raddr, resp_data;
  logic [7:0]       resp_status;

  assign rst_p = ~cpu_rstn;

  ff_sync #(.WIDTH(1)) u_ack_sync (
    .clk   (cpu_clk),
    .rst_p (rst_p),
    .d     (bus.jtag_ack_toggle),
    .q     (ack_sync)
  );

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    publish     = 1'b0;
    timed_out   = 1'b0;
    serviced    = bus.req_valid && is_read_op(bus.req_op);
    overrun_set = serviced && (state != ST_IDLE);
    case (state)
      ST_IDLE:    if (serviced) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                  end
      ST_ISSUE:   state_nxt = ST_WAIT;
      ST_WAIT:    if (rvalid_p1) begin
                    publish   = 1'b1;
                    state_nxt = ST_PUBLISH;
                  end else if (wait_cnt == CNT_LAST) begin
                    publish   = 1'b1;
                    timed_out = 1'b1;
                    state_nxt = ST_PUBLISH;
                  end
      ST_PUBLISH: if (ack_sync == resp_toggle) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    seq_inc                      = seq + SEQ_W'(1);
    status_nxt                   = '0;
    status_nxt[STAT_TIMEOUT_BIT] = timed_out;
    status_nxt[STAT_OVERRUN_BIT] = overrun;
    status_nxt[SEQ_W-1:0]        = seq_inc;
  end

  // Stage p1: selected memory's return is registered, and only while waiting for it
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      rvalid_p1 <= (state == ST_WAIT) && (sel_dmem ? bus.dmem_rvalid : bus.imem_rvalid);
      rdata_p1  <= sel_dmem ? bus.dmem_rdata : bus.imem_rdata;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      imem_re     <= 1'b0;
      dmem_re     <= 1'b0;
      mem_raddr   <= '0;
      sel_dmem    <= 1'b0;
      wait_cnt    <= '0;
      resp_data   <= '0;
      resp_status <= '0;
      resp_toggle <= 1'b0;
      overrun     <= 1'b0;
      seq         <= '0;
    end else begin
      imem_re  <= accept && (bus.req_op == DBG_OP_READIMEM);
      dmem_re  <= accept && (bus.req_op == DBG_OP_READDMEM);
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
      if (accept) begin
        mem_raddr <= bus.req_addr;
        sel_dmem  <= (bus.req_op == DBG_OP_READDMEM);
      end
      // Data, status and toggle move on the same edge so the JTAG side never sees a mix
      if (publish) begin
        resp_data   <= timed_out ? 32'h0 : rdata_p1;
        resp_status <= status_nxt;
        resp_toggle <= ~resp_toggle;
        seq         <= seq_inc;
      end
      // A drop on the publish edge survives into the following response
      overrun <= (overrun && !publish) || overrun_set;
    end
  end

  assign bus.imem_re     = imem_re;
  assign bus.dmem_re     = dmem_re;
  assign bus.mem_raddr   = mem_raddr;
  assign bus.resp_data   = resp_data;
  assign bus.resp_status = resp_status;
  assign bus.resp_toggle = resp_toggle;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_debug_readback.sv
// Randomized bench for debug_readback; expectations come from a transaction-level model.
module tb_debug_readback;
  localparam int T = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  debug_readback_if bus();

  debug_readback #(.TIMEOUT_CYCLES(T)) dut (
    .cpu_clk  (clk),
    .cpu_rstn (rstn),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model: sequence number, expected toggle, pending overrun
  logic [3:0] m_seq = 4'd0;
  logic       m_tog = 1'b0;
  logic       m_ov  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid   = 1'b0;
    bus.req_op      = 8'h00;
    bus.req_addr    = 32'h0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},   32'(bus.busy), 0);
    check({pfx, "_strobe"}, 32'({bus.dmem_re, bus.imem_re}), 0);
    check({pfx, "_raddr"},  bus.mem_raddr, 0);
    check({pfx, "_data"},   bus.resp_data, 0);
    check({pfx, "_status"}, 32'(bus.resp_status), 0);
    check({pfx, "_toggle"}, 32'(bus.resp_toggle), 0);
  endtask

  // d: cycles after the strobe cycle at which the selected rvalid is driven.
  // ov_mode: 0 none, 1 extra request before publish, 2 on the publish edge, 3 during PUBLISH.
  task automatic read_txn(input bit dm, input logic [31:0] addr, input int d,
                          input logic [31:0] data, input int ov_mode, input int ack_dly);
    bit         to, done, sel_v;
    int         pub_exp, pub_j, ack_j, ov_j, late_j, strobes;
    logic       tog0;
    logic [7:0] st_exp;
    logic [31:0] d_exp, sel_d;

    to      = (d >= T);
    pub_exp = to ? T + 1 : d + 2;
    d_exp   = to ? 32'h0 : data;
    late_j  = to ? pub_exp + 1 : -1;
    case (ov_mode)
      1:       ov_j = $urandom_range(0, pub_exp - 2);
      2:       ov_j = pub_exp - 1;
      3:       ov_j = pub_exp;
      default: ov_j = -1;
    endcase

    m_seq  = m_seq + 4'd1;
    m_tog  = ~m_tog;
    st_exp = {to, m_ov | (ov_mode == 1), 2'b00, m_seq};
    m_ov   = (ov_mode == 2) || (ov_mode == 3);

    tog0          = bus.resp_toggle;
    bus.req_valid = 1'b1;
    bus.req_op    = dm ? 8'h06 : 8'h04;
    bus.req_addr  = addr;
    tick;

    pub_j = -1; ack_j = -1; strobes = 0; done = 1'b0;
    for (int j = 0; j < T + 16; j++) begin
      if (bus.imem_re || bus.dmem_re) strobes++;
      if (j == 0) begin
        check("strobe_sel", 32'({bus.dmem_re, bus.imem_re}), dm ? 32'd2 : 32'd1);
        check("raddr",      bus.mem_raddr, addr);
        check("busy_set",   32'(bus.busy), 1);
      end
      if (pub_j < 0 && bus.resp_toggle !== tog0) begin
        pub_j = j;
        check("latency",     pub_j, pub_exp);
        check("resp_data",   bus.resp_data, d_exp);
        check("resp_status", 32'(bus.resp_status), 32'(st_exp));
        check("resp_toggle", 32'(bus.resp_toggle), 32'(m_tog));
        ack_j = j + ack_dly;
      end
      if (ack_j >= 0 && j == ack_j + 2) check("busy_hold", 32'(bus.busy), 1);
      if (ack_j >= 0 && j == ack_j + 3) begin
        check("busy_clear", 32'(bus.busy), 0);
        done = 1'b1;
        break;
      end
      bus.req_valid = (j == ov_j);
      bus.req_op    = $urandom_range(0, 1) ? 8'h04 : 8'h06;
      bus.req_addr  = $urandom;
      sel_v         = (j == d) || (j == late_j);
      sel_d         = (j == d) ? data : $urandom;
      if (dm) begin
        bus.dmem_rvalid = sel_v;
        bus.dmem_rdata  = sel_d;
        bus.imem_rvalid = 1'($urandom_range(0, 1));
        bus.imem_rdata  = $urandom;
      end else begin
        bus.imem_rvalid = sel_v;
        bus.imem_rdata  = sel_d;
        bus.dmem_rvalid = 1'($urandom_range(0, 1));
        bus.dmem_rdata  = $urandom;
      end
      if (j == ack_j) bus.jtag_ack_toggle = m_tog;
      tick;
    end
    if (!done) check("txn_done", 32'(done), 1);
    check("strobe_count", strobes, 1);
    check("data_hold",    bus.resp_data, d_exp);
    idle_inputs();
  endtask

  task automatic ignored_op(input logic [7:0] op);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = $urandom;
    tick;
    bus.req_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("ign_busy",   32'(bus.busy), 0);
      check("ign_strobe", 32'({bus.dmem_re, bus.imem_re}), 0);
      tick;
    end
  endtask

  initial begin
    logic [7:0] op;
    idle_inputs();
    bus.jtag_ack_toggle = 1'b0;
    rstn = 1'b0;
    repeat (3) tick;
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick;

    // Directed: fast imem read, then a timeout with late data
    read_txn(1'b0, 32'h100, 1, 32'hCAFEF00D, 0, 0);
    read_txn(1'b1, $urandom, T + 1, $urandom, 0, 2);
    // Overrun while publishing, carried once then cleared
    read_txn(1'b1, $urandom, 2, $urandom, 3, 1);
    read_txn(1'b0, $urandom, 3, $urandom, 0, 0);
    read_txn(1'b1, $urandom, 1, $urandom, 0, 0);

    ignored_op(8'h05);
    ignored_op(8'h80);
    for (int k = 0; k < 4; k++) begin
      op = 8'($urandom);
      if (op == 8'h04 || op == 8'h06) op = 8'h07;
      ignored_op(op);
    end
    read_txn(1'b0, $urandom, 1, $urandom, 0, 0);

    for (int k = 0; k < 40; k++)
      read_txn(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, T + 1), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset while waiting for read data, with rvalid arriving during reset
    bus.req_valid = 1'b1;
    bus.req_op    = 8'h04;
    bus.req_addr  = $urandom;
    tick;
    bus.req_valid = 1'b0;
    tick;
    tick;
    #2;
    rstn                = 1'b0;
    bus.jtag_ack_toggle = 1'b0;
    bus.imem_rvalid     = 1'b1;
    bus.imem_rdata      = 32'h12345678;
    #1;
    check_reset_outputs("midrst");
    tick;
    tick;
    check_reset_outputs("midrst_hold");
    rstn = 1'b1;
    idle_inputs();
    m_seq = 4'd0;
    m_tog = 1'b0;
    m_ov  = 1'b0;
    tick;
    read_txn(1'b0, $urandom, 1, $urandom, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
